// File: rtl/sort_controller.sv
`default_nettype none
// ============================================================================
// Module   : sort_controller
// Purpose  : Sequencer for an N-entry in-place ascending exchange sort, with a
//            single-entry readback path.
// Revision : 1.0
// ============================================================================
module sort_controller #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic          AgtB,
    input  logic          zi,
    input  logic          zj,
    output logic          EA,
    output logic          EB,
    output logic          WR,
    output logic          Csel,
    output logic          Bout,
    output logic          Li,
    output logic          Lj,
    output logic          Ei,
    output logic          Ej,
    output logic          Rd,
    output logic [AW-1:0] i_in,
    output logic [AW-1:0] j_in,
    output logic          busy,
    output logic          done,
    output logic          rd_valid,
    output logic          err
);

    localparam logic [AW-1:0] c_zero   = '0;
    localparam logic [AW-1:0] c_one    = AW'(1);
    localparam logic [AW-1:0] c_two    = AW'(2);
    localparam logic [AW-1:0] c_last_j = AW'(N - 1);
    localparam logic [AW-1:0] c_last_i = AW'(N - 2);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        LOAD  = 4'd2,
        CMP   = 4'd3,
        SWAP1 = 4'd4,
        SWAP2 = 4'd5,
        NEXTJ = 4'd6,
        NEXTI = 4'd7,
        DONE  = 4'd8,
        RDLD  = 4'd9,
        RD    = 4'd10
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_cnt_q, i_cnt_d;
    logic [AW-1:0] j_cnt_q, j_cnt_d;
    logic          err_q, err_d;

    logic          ea_q, ea_d, eb_q, eb_d, wr_q, wr_d, csel_q, csel_d;
    logic          bout_q, bout_d, li_q, li_d, lj_q, lj_d, ei_q, ei_d;
    logic          ej_q, ej_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [AW-1:0] i_in_q, i_in_d, j_in_q, j_in_d;

    // The i==0 flag carries no information the shadow counters lack.
    logic          unused_zi;
    assign unused_zi = zi;

    always_comb begin
        state_d = state_q;
        i_cnt_d = i_cnt_q;
        j_cnt_d = j_cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                end else if (rd_req) begin
                    state_d = RDLD;
                end
            end
            RDLD:  state_d = RD;
            RD:    state_d = IDLE;
            INIT: begin
                i_cnt_d = c_zero;
                j_cnt_d = c_one;
                state_d = LOAD;
            end
            LOAD: begin
                if (zj) begin
                    err_d = 1'b1;
                end
                state_d = CMP;
            end
            CMP:   state_d = AgtB ? SWAP1 : NEXTJ;
            SWAP1: state_d = SWAP2;
            SWAP2: state_d = NEXTJ;
            NEXTJ: begin
                if (j_cnt_q == c_last_j) begin
                    state_d = NEXTI;
                end else begin
                    j_cnt_d = j_cnt_q + c_one;
                    state_d = LOAD;
                end
            end
            NEXTI: begin
                if (i_cnt_q == c_last_i) begin
                    state_d = DONE;
                end else begin
                    i_cnt_d = i_cnt_q + c_one;
                    j_cnt_d = i_cnt_q + c_two;
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so each
    // state presents its controls for exactly the cycle it is resident.
    always_comb begin
        ea_d       = 1'b0;
        eb_d       = 1'b0;
        wr_d       = 1'b0;
        csel_d     = 1'b0;
        bout_d     = 1'b0;
        li_d       = 1'b0;
        lj_d       = 1'b0;
        ei_d       = 1'b0;
        ej_d       = 1'b0;
        rd_d       = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        i_in_d     = c_zero;
        j_in_d     = c_zero;
        busy_d     = (state_d != IDLE);
        case (state_d)
            RDLD: begin
                li_d   = 1'b1;
                i_in_d = rd_addr;
            end
            RD: begin
                rd_d       = 1'b1;
                rd_valid_d = 1'b1;
            end
            INIT: begin
                li_d   = 1'b1;
                lj_d   = 1'b1;
                i_in_d = c_zero;
                j_in_d = c_one;
            end
            LOAD: begin
                ea_d = 1'b1;
                eb_d = 1'b1;
            end
            SWAP1: begin
                wr_d   = 1'b1;
                csel_d = 1'b1;
                bout_d = 1'b1;
            end
            SWAP2: wr_d = 1'b1;
            NEXTJ: ej_d = (j_cnt_d != c_last_j);
            NEXTI: begin
                ei_d   = (i_cnt_d != c_last_i);
                lj_d   = (i_cnt_d != c_last_i);
                j_in_d = (i_cnt_d != c_last_i) ? (i_cnt_d + c_two) : c_zero;
            end
            DONE:    done_d = 1'b1;
            default: busy_d = (state_d != IDLE);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_cnt_q    <= c_zero;
            j_cnt_q    <= c_zero;
            err_q      <= 1'b0;
            ea_q       <= 1'b0;
            eb_q       <= 1'b0;
            wr_q       <= 1'b0;
            csel_q     <= 1'b0;
            bout_q     <= 1'b0;
            li_q       <= 1'b0;
            lj_q       <= 1'b0;
            ei_q       <= 1'b0;
            ej_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            i_in_q     <= c_zero;
            j_in_q     <= c_zero;
        end else begin
            state_q    <= state_d;
            i_cnt_q    <= i_cnt_d;
            j_cnt_q    <= j_cnt_d;
            err_q      <= err_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            wr_q       <= wr_d;
            csel_q     <= csel_d;
            bout_q     <= bout_d;
            li_q       <= li_d;
            lj_q       <= lj_d;
            ei_q       <= ei_d;
            ej_q       <= ej_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            i_in_q     <= i_in_d;
            j_in_q     <= j_in_d;
        end
    end

    assign EA       = ea_q;
    assign EB       = eb_q;
    assign WR       = wr_q;
    assign Csel     = csel_q;
    assign Bout     = bout_q;
    assign Li       = li_q;
    assign Lj       = lj_q;
    assign Ei       = ei_q;
    assign Ej       = ej_q;
    assign Rd       = rd_q;
    assign i_in     = i_in_q;
    assign j_in     = j_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;

endmodule
`default_nettype wire
